shift_serdes: RTL

//   Parametrised serial shift engine: generalises the fixed 3-bit serial-in/serial-out register
//   to WIDTH bits, selectable bit order, parallel load and parallel capture.

---
 rtl/shift_serdes.sv | 128 ++++++++++++
 1 files changed

// File: rtl/shift_serdes.sv
// ============================================================================
// shift_serdes
// ----------------------------------------------------------------------------
// Parametrised serial shift engine. A parallel word accepted on the input
// handshake is shifted out on `so` one bit per `shift_en` strobe, while a new
// word is shifted in from `si` at the same time. When the last bit has been
// shifted, the received word is presented on the output handshake. Overwriting
// an unconsumed word sets the sticky `overrun` flag.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: MSB out first, shift left, si enters bit 0
//              0: LSB out first, shift right, si enters bit WIDTH-1
//
// Ports
//   clk        rising-edge clock
//   clear      synchronous active-high reset, dominant over all inputs
//   in_valid   parallel word offered
//   in_ready   word accepted on in_valid & in_ready (IDLE and not in clear)
//   in_data    parallel word to transmit
//   shift_en   one shift per edge while high (SHIFT state only)
//   si         serial input, sampled on each shift
//   so         serial output (0 while idle)
//   frame      high while a word is in flight
//   bit_cnt    shifts completed in the current word
//   out_valid  received word available
//   out_ready  consumer takes the word on out_valid & out_ready
//   out_data   received word
//   overrun    sticky: a received word overwrote an unconsumed one
// ============================================================================
module shift_serdes #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CNT_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_en,
    input  logic             si,
    output logic             so,
    output logic             frame,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overrun
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic             state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;

    // The vacated end takes si, so the first bit received lands where the
    // first bit transmitted came from; looping so back to si returns the word.
    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        shifted = shreg;
        if (MSB_FIRST) begin
            shifted = {shreg[WIDTH-2:0], si};
        end else begin
            shifted = {si, shreg[WIDTH-1:1]};
        end
    end

    assign last_bit = (bit_cnt == LAST_BIT);
    assign frame    = (state == S_SHIFT);
    assign in_ready = (state == S_IDLE) & ~clear;

    // Gated while idle: the register still holds the last shifted value.
    assign so = frame & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A consumption and a completion on the same edge: the completion
            // below wins and re-asserts out_valid for the new word.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg   <= in_data;
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (shift_en) begin
                        shreg <= shifted;
                        if (last_bit) begin
                            out_data  <= shifted;
                            out_valid <= 1'b1;
                            if (out_valid && !out_ready) begin
                                overrun <= 1'b1;
                            end
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
